// File: rtl/pwm_duty_meter.sv
// PWM receiver: measures on-time and period of an incoming PWM line in clk
// cycles and flags a line that stops toggling.
module pwm_duty_meter #(
  parameter int unsigned CNT_W      = 25,
  parameter int unsigned TIMEOUT    = 3000000,
  parameter bit          ACTIVE_LOW = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en_meas,
  input  logic             pwm_in,
  output logic [CNT_W-1:0] on_cnt,
  output logic [CNT_W-1:0] period_cnt,
  output logic             meas_valid,
  output logic             stuck,
  output logic             stuck_level
);

  localparam logic [CNT_W-1:0] LP_TO  = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] LP_ONE = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE,
    ARM,
    HIGH,
    LOW
  } state_t;

  state_t           r_state;
  logic             r_sync1;
  logic             r_sync2;
  logic             r_s_d;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_on_len;
  logic [CNT_W-1:0] r_on_cnt;
  logic [CNT_W-1:0] r_period_cnt;
  logic             r_valid;
  logic             r_stuck;
  logic             r_stuck_lvl;

  logic             w_s;
  logic             w_rise;
  logic             w_fall;
  logic             w_edge;
  logic             w_tmo;
  logic [CNT_W-1:0] w_inc;

  assign w_s    = r_sync2 ^ ACTIVE_LOW;
  assign w_rise = w_s & ~r_s_d;
  assign w_fall = ~w_s & r_s_d;
  assign w_edge = w_rise | w_fall;
  assign w_inc  = (r_cnt == LP_TO) ? LP_TO : r_cnt + LP_ONE;
  // An edge landing on the timeout cycle takes priority over stuck.
  assign w_tmo  = (r_state != IDLE) && (r_cnt == LP_TO) && !w_edge;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1      <= ACTIVE_LOW;
      r_sync2      <= ACTIVE_LOW;
      r_s_d        <= 1'b0;
      r_state      <= IDLE;
      r_cnt        <= '0;
      r_on_len     <= '0;
      r_on_cnt     <= '0;
      r_period_cnt <= '0;
      r_valid      <= 1'b0;
      r_stuck      <= 1'b0;
      r_stuck_lvl  <= 1'b0;
    end else begin
      r_sync1 <= pwm_in;
      r_sync2 <= r_sync1;
      r_s_d   <= w_s;
      r_valid <= 1'b0;
      if (!en_meas) begin
        r_state  <= IDLE;
        r_cnt    <= '0;
        r_on_len <= '0;
      end else if (w_tmo) begin
        r_stuck      <= 1'b1;
        r_stuck_lvl  <= w_s;
        r_on_cnt     <= w_s ? LP_TO : '0;
        r_period_cnt <= LP_TO;
        r_valid      <= 1'b1;
        r_cnt        <= '0;
        r_state      <= ARM;
      end else begin
        unique case (r_state)
          IDLE: begin
            r_cnt   <= '0;
            r_state <= ARM;
          end
          ARM: begin
            if (w_rise) begin
              r_cnt   <= LP_ONE;
              r_state <= HIGH;
            end else begin
              r_cnt <= w_inc;
            end
          end
          HIGH: begin
            r_cnt <= w_inc;
            if (w_fall) begin
              r_on_len <= r_cnt;
              r_state  <= LOW;
            end
          end
          LOW: begin
            if (w_rise) begin
              r_on_cnt     <= r_on_len;
              r_period_cnt <= r_cnt;
              r_valid      <= 1'b1;
              r_stuck      <= 1'b0;
              r_cnt        <= LP_ONE;
              r_state      <= HIGH;
            end else begin
              r_cnt <= w_inc;
            end
          end
        endcase
      end
    end
  end

  assign on_cnt      = r_on_cnt;
  assign period_cnt  = r_period_cnt;
  assign meas_valid  = r_valid;
  assign stuck       = r_stuck;
  assign stuck_level = r_stuck_lvl;

endmodule
